// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: register-address
// width, the $zero index, counter widths and the hazard FSM state encoding.
package mips_pipe_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned STALL_CNT_W = 2;
    localparam int unsigned PERF_CNT_W  = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(0);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_e;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating performance counters for the hazard controller: cycles with the
// PC held, and cycles with any IF/ID or ID/EX flush.
module hazard_perf_cnt
    import mips_pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_inc_i,
    input  logic                  flush_inc_i,
    output logic [PERF_CNT_W-1:0] stall_cycles_o,
    output logic [PERF_CNT_W-1:0] flush_events_o
);

    logic [PERF_CNT_W-1:0] stall_q;
    logic [PERF_CNT_W-1:0] flush_q;

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc_i && (stall_q != '1)) begin
                stall_q <= stall_q + PERF_CNT_W'(1);
            end
            if (flush_inc_i && (flush_q != '1)) begin
                flush_q <= flush_q + PERF_CNT_W'(1);
            end
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_events_o = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller for the five-stage MIPS core.
// Flush/Hold outputs are combinational from inputs and registered state.
// Optional: define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned JR_LOAD_STALL = 2,
    parameter int unsigned JR_ALU_STALL  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] IFID_Rs,
    input  logic [REG_ADDR_W-1:0] IFID_Rt,
    input  logic                  IFID_UsesRt,
    input  logic                  ID_Jump,
    input  logic                  ID_JR,
    input  logic                  IDEX_MemRd,
    input  logic                  IDEX_RegWr,
    input  logic [REG_ADDR_W-1:0] IDEX_WrAddr,
    input  logic                  EX_BranchTaken,
    input  logic                  EXMEM_MemAcc,
    input  logic                  mem_ready,
    output logic                  PC_Hold,
    output logic                  IFID_Hold,
    output logic                  IDEX_Hold,
    output logic                  EXMEM_Hold,
    output logic                  IFID_Flush,
    output logic                  IDEX_Flush,
    output logic                  MEMWB_Flush,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_events
);

    hazard_state_e          state_q, state_d;
    hazard_state_e          ret_q, ret_d;
    logic [STALL_CNT_W-1:0] stall_left_q, stall_left_d;

    logic                   mem_wait_c;
    logic                   in_stall_c;
    logic                   jr_dep_c;
    logic                   load_use_c;
    logic [STALL_CNT_W-1:0] jr_n_c;

    // Hazard conditions; $0 as a destination never creates a dependency.
    assign mem_wait_c = EXMEM_MemAcc & ~mem_ready;
    assign in_stall_c = (state_q == STALL) | ((state_q == MEM_WAIT) & (ret_q == STALL));
    assign jr_dep_c   = ID_JR & IDEX_RegWr & (IDEX_WrAddr != ZERO_REG)
                        & (IDEX_WrAddr == IFID_Rs);
    assign load_use_c = IDEX_MemRd & (IDEX_WrAddr != ZERO_REG)
                        & ((IDEX_WrAddr == IFID_Rs)
                           | (IFID_UsesRt & (IDEX_WrAddr == IFID_Rt)));
    assign jr_n_c     = IDEX_MemRd ? STALL_CNT_W'(JR_LOAD_STALL)
                                   : STALL_CNT_W'(JR_ALU_STALL);

    // State, return state and remaining stall count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            ret_q        <= RUN;
            stall_left_q <= '0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            stall_left_q <= stall_left_d;
        end
    end

    // Prioritised hazard resolution: next state and Flush/Hold outputs.
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        stall_left_d = stall_left_q;
        PC_Hold      = 1'b0;
        IFID_Hold    = 1'b0;
        IDEX_Hold    = 1'b0;
        EXMEM_Hold   = 1'b0;
        IFID_Flush   = 1'b0;
        IDEX_Flush   = 1'b0;
        MEMWB_Flush  = 1'b0;

        if (mem_wait_c) begin
            PC_Hold     = 1'b1;
            IFID_Hold   = 1'b1;
            IDEX_Hold   = 1'b1;
            EXMEM_Hold  = 1'b1;
            MEMWB_Flush = 1'b1;
            state_d     = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                ret_d = state_q;
            end
        end else if (EX_BranchTaken) begin
            IFID_Flush   = 1'b1;
            IDEX_Flush   = 1'b1;
            stall_left_d = '0;
            state_d      = RUN;
        end else if (in_stall_c) begin
            PC_Hold      = 1'b1;
            IFID_Hold    = 1'b1;
            IDEX_Flush   = 1'b1;
            stall_left_d = stall_left_q - STALL_CNT_W'(1);
            state_d      = (stall_left_q <= STALL_CNT_W'(1)) ? RUN : STALL;
        end else if (jr_dep_c) begin
            PC_Hold    = 1'b1;
            IFID_Hold  = 1'b1;
            IDEX_Flush = 1'b1;
            if (jr_n_c > STALL_CNT_W'(1)) begin
                stall_left_d = jr_n_c - STALL_CNT_W'(1);
                state_d      = STALL;
            end else begin
                state_d = RUN;
            end
        end else if (load_use_c) begin
            PC_Hold    = 1'b1;
            IFID_Hold  = 1'b1;
            IDEX_Flush = 1'b1;
            state_d    = RUN;
        end else if (ID_Jump) begin
            IFID_Flush = 1'b1;
            state_d    = RUN;
        end else begin
            state_d = RUN;
        end

        if (reset) begin
            PC_Hold     = 1'b0;
            IFID_Hold   = 1'b0;
            IDEX_Hold   = 1'b0;
            EXMEM_Hold  = 1'b0;
            IFID_Flush  = 1'b0;
            IDEX_Flush  = 1'b0;
            MEMWB_Flush = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Stall and flush event counters.
    hazard_perf_cnt u_perf_cnt (
        .clk            (clk),
        .reset          (reset),
        .stall_inc_i    (PC_Hold),
        .flush_inc_i    (IFID_Flush | IDEX_Flush),
        .stall_cycles_o (stall_cycles),
        .flush_events_o (flush_events)
    );
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with a queue-based scoreboard.
module tb_hazard_ctrl;

    localparam logic [6:0] NON = 7'b0000000;
    localparam logic [6:0] STV = 7'b1100010; // PC/IFID hold + IDEX flush
    localparam logic [6:0] BRV = 7'b0000110; // IFID + IDEX flush
    localparam logic [6:0] JMV = 7'b0000100; // IFID flush
    localparam logic [6:0] MWV = 7'b1111001; // all holds + MEMWB flush
`ifdef HAZARD_PERF_CNT_EN
    localparam logic [31:0] CNT_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] CNT_MASK = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  IFID_Rs = '0, IFID_Rt = '0, IDEX_WrAddr = '0;
    logic        IFID_UsesRt = 0, ID_Jump = 0, ID_JR = 0, IDEX_MemRd = 0, IDEX_RegWr = 0;
    logic        EX_BranchTaken = 0, EXMEM_MemAcc = 0, mem_ready = 1;
    logic        PC_Hold, IFID_Hold, IDEX_Hold, EXMEM_Hold;
    logic        IFID_Flush, IDEX_Flush, MEMWB_Flush;
    logic [31:0] stall_cycles, flush_events;
    logic [6:0]  obs;

    logic [6:0]  exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .ID_Jump(ID_Jump), .ID_JR(ID_JR),
        .IDEX_MemRd(IDEX_MemRd), .IDEX_RegWr(IDEX_RegWr), .IDEX_WrAddr(IDEX_WrAddr),
        .EX_BranchTaken(EX_BranchTaken), .EXMEM_MemAcc(EXMEM_MemAcc), .mem_ready(mem_ready),
        .PC_Hold(PC_Hold), .IFID_Hold(IFID_Hold), .IDEX_Hold(IDEX_Hold), .EXMEM_Hold(EXMEM_Hold),
        .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .MEMWB_Flush(MEMWB_Flush),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    assign obs = {PC_Hold, IFID_Hold, IDEX_Hold, EXMEM_Hold, IFID_Flush, IDEX_Flush, MEMWB_Flush};

    function automatic logic [31:0] cnt(input int v);
        return 32'(v) & CNT_MASK;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge.
    task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic jmp, input logic jr, input logic mrd, input logic rwr,
                       input logic [4:0] wa, input logic br, input logic macc, input logic rdy);
        @(posedge clk);
        #1;
        IFID_Rs = rs; IFID_Rt = rt; IFID_UsesRt = urt; ID_Jump = jmp; ID_JR = jr;
        IDEX_MemRd = mrd; IDEX_RegWr = rwr; IDEX_WrAddr = wa;
        EX_BranchTaken = br; EXMEM_MemAcc = macc; mem_ready = rdy;
    endtask

    task automatic expo(input logic [6:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic set_idle();
        IFID_Rs = '0; IFID_Rt = '0; IFID_UsesRt = 0; ID_Jump = 0; ID_JR = 0;
        IDEX_MemRd = 0; IDEX_RegWr = 0; IDEX_WrAddr = '0;
        EX_BranchTaken = 0; EXMEM_MemAcc = 0; mem_ready = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        set_idle();
        #1;
        chk("rst_outputs", 32'(obs), 32'(NON));
        @(posedge clk);
        #1;
        chk("rst_stall_cnt", stall_cycles, 32'd0);
        chk("rst_flush_cnt", flush_events, 32'd0);
        reset = 1'b0;
    endtask

    // Monitor: compare the outputs of each driven cycle on the falling edge.
    initial begin
        logic [6:0] e;
        string      n;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                chk(n, 32'(obs), 32'(e));
            end
        end
    end

    initial begin
        // Load-use via Rs and Rt, $0 destination, load-use vs branch.
        do_reset();
        drv(8, 1, 1, 0, 0, 1, 1, 8, 0, 0, 1); expo(STV, "lu_rs");
        drv(8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1); expo(NON, "lu_rs_after");
        #1 chk("lu_stall_cnt", stall_cycles, cnt(1));
        drv(3, 8, 1, 0, 0, 1, 1, 8, 0, 0, 1); expo(STV, "lu_rt");
        drv(3, 8, 0, 0, 0, 1, 1, 8, 0, 0, 1); expo(NON, "lu_rt_unused");
        drv(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1); expo(NON, "lu_zero_dest");
        drv(8, 1, 1, 0, 0, 1, 1, 8, 1, 0, 1); expo(BRV, "lu_vs_branch");
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); expo(NON, "lu_idle");
        #1 chk("lu_stall_total", stall_cycles, cnt(2));
        chk("lu_flush_total", flush_events, cnt(3));

        // JR on load (2 cycles), JR on ALU (1 cycle), $0, jumps.
        do_reset();
        drv(31, 0, 0, 0, 1, 1, 1, 31, 0, 0, 1); expo(STV, "jrl_1");
        drv(31, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1); expo(STV, "jrl_2");
        drv(31, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1); expo(NON, "jrl_done");
        drv(31, 0, 0, 0, 1, 0, 1, 31, 0, 0, 1); expo(STV, "jra_1");
        drv(31, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1); expo(NON, "jra_done");
        drv(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1); expo(NON, "jr_zero_dest");
        drv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1); expo(JMV, "jump");
        drv(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1); expo(BRV, "jump_vs_branch");
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); expo(NON, "jr_idle");
        #1 chk("jr_stall_cnt", stall_cycles, cnt(3));
        chk("jr_flush_cnt", flush_events, cnt(5));

        // Taken branch during the second JR stall cycle.
        do_reset();
        drv(31, 0, 0, 0, 1, 1, 1, 31, 0, 0, 1); expo(STV, "jrb_1");
        drv(31, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1); expo(BRV, "jrb_branch");
        drv(31, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1); expo(NON, "jrb_run");
        #1 chk("jrb_stall_cnt", stall_cycles, cnt(1));
        chk("jrb_flush_cnt", flush_events, cnt(2));

        // Memory wait from RUN, with a held branch, and across a STALL.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); expo(MWV, "mw_wait");
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); expo(NON, "mw_release");
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); expo(MWV, "mw_branch_held");
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); expo(BRV, "mw_branch_go");
        drv(31, 0, 0, 0, 1, 1, 1, 31, 0, 0, 1); expo(STV, "mws_1");
        drv(31, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0); expo(MWV, "mws_wait1");
        drv(31, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0); expo(MWV, "mws_wait2");
        drv(31, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1); expo(STV, "mws_resume");
        drv(31, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1); expo(NON, "mws_done");
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); expo(NON, "mw_idle");
        #1 chk("mw_stall_cnt", stall_cycles, cnt(8));
        chk("mw_flush_cnt", flush_events, cnt(3));

        // Asynchronous reset in the middle of a JR stall.
        do_reset();
        drv(31, 0, 0, 0, 1, 1, 1, 31, 0, 0, 1); expo(STV, "rst_pre");
        @(posedge clk);
        #1;
        IDEX_MemRd = 0; IDEX_RegWr = 0; IDEX_WrAddr = '0;
        #1 chk("rst_in_stall", 32'(obs), 32'(STV));
        reset = 1'b1;
        #1 chk("rst_async_out", 32'(obs), 32'(NON));
        @(posedge clk);
        #1;
        chk("rst_mid_stall_cnt", stall_cycles, 32'd0);
        chk("rst_mid_flush_cnt", flush_events, 32'd0);
        reset = 1'b0;
        drv(31, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1); expo(NON, "rst_after_run");
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); expo(NON, "rst_idle");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
